spindash_write_sched: RTL and testbench

SPINDASH_WRITE_SCHED -- requirements
Module: spindash_write_sched

---
 rtl/spindash_pkg.sv | 26 ++
 rtl/spindash_fifo.sv | 55 +++++
 rtl/spindash_write_sched.sv | 155 +++++++++++++++
 tb/tb_spindash_write_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spindash_pkg.sv
// Shared types and constants for the jt12 write scheduler.
package spindash_pkg;

  localparam int unsigned CS_W          = 5;
  localparam int unsigned ADDR_W        = 2;
  localparam int unsigned DIN_W         = 8;
  localparam int unsigned TIMER_W       = 7;
  localparam int unsigned ADDR_WAIT_DEF = 17;
  localparam int unsigned DATA_WAIT_DEF = 83;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } sched_state_t;

  typedef struct packed {
    logic [CS_W-1:0]   cs;
    logic [ADDR_W-1:0] addr;
    logic [DIN_W-1:0]  din;
  } wr_entry_t;

  localparam int unsigned ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/spindash_fifo.sv
// Single-clock FIFO with registered occupancy; push is ignored when full.
module spindash_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 15
) (
  input  logic                     clk_jt,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rptr];

  // Storage array, written on accepted push.
  always_ff @(posedge clk_jt) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers and occupancy; simultaneous push and pop leave level unchanged.
  always_ff @(posedge clk_jt) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spindash_write_sched.sv
// Queues host writes and replays them onto the jt12 bus, respecting per-chip busy time.
module spindash_write_sched
  import spindash_pkg::*;
#(
  parameter int unsigned YM_COUNT   = 7,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WAIT  = ADDR_WAIT_DEF,
  parameter int unsigned DATA_WAIT  = DATA_WAIT_DEF
) (
  input  logic                          clk_jt,
  input  logic                          rst,
  input  logic                          cen,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4:0]                    in_cs,
  input  logic [1:0]                    in_addr,
  input  logic [7:0]                    in_din,
  output logic [4:0]                    ym_cs,
  output logic [1:0]                    ym_addr,
  output logic [7:0]                    ym_din,
  output logic                          ym_wr_n,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          err_cs,
  output logic                          busy
);

  sched_state_t       r_state, w_state_nxt;
  wr_entry_t          w_in_entry, w_head;
  logic               w_push, w_pop, w_full, w_empty;
  logic               w_head_ok, w_head_free, w_timers_idle;
  logic               w_load, w_err_nxt, w_wr_n_nxt;
  logic [4:0]         w_cs_nxt;
  logic [1:0]         w_addr_nxt;
  logic [7:0]         w_din_nxt;
  logic [TIMER_W-1:0] w_load_val;
  logic [4:0]         r_ym_cs;
  logic [1:0]         r_ym_addr;
  logic [7:0]         r_ym_din;
  logic               r_ym_wr_n;
  logic               r_err;
  logic [TIMER_W-1:0] r_timer [YM_COUNT];

  assign w_in_entry = {in_cs, in_addr, in_din};
  assign w_push     = in_valid && !w_full;
  assign in_ready   = !w_full;

  spindash_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_jt  (clk_jt),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_in_entry),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Head entry validity and whether its target chip is free; any chip still busy.
  always_comb begin
    w_head_ok     = (w_head.cs != '0) && (32'(w_head.cs) <= YM_COUNT);
    w_head_free   = 1'b0;
    w_timers_idle = 1'b1;
    for (int i = 0; i < int'(YM_COUNT); i++) begin
      if (w_head.cs == 5'(i + 1)) w_head_free = (r_timer[i] == '0);
      if (r_timer[i] != '0)       w_timers_idle = 1'b0;
    end
  end

  assign w_load_val = r_ym_addr[0] ? TIMER_W'(DATA_WAIT) : TIMER_W'(ADDR_WAIT);

  // Bus phase sequencing; every transition waits for cen.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_cs_nxt    = r_ym_cs;
    w_addr_nxt  = r_ym_addr;
    w_din_nxt   = r_ym_din;
    w_wr_n_nxt  = r_ym_wr_n;
    if (cen) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (!w_head_ok) begin
              w_pop     = 1'b1;
              w_err_nxt = 1'b1;
            end else if (w_head_free) begin
              w_pop       = 1'b1;
              w_cs_nxt    = w_head.cs;
              w_addr_nxt  = w_head.addr;
              w_din_nxt   = w_head.din;
              w_wr_n_nxt  = 1'b1;
              w_state_nxt = ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          w_wr_n_nxt  = 1'b0;
          w_state_nxt = ST_STROBE;
        end
        ST_STROBE: begin
          w_wr_n_nxt  = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          w_cs_nxt    = '0;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and registered bus outputs.
  always_ff @(posedge clk_jt) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ym_cs   <= '0;
      r_ym_addr <= '0;
      r_ym_din  <= '0;
      r_ym_wr_n <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ym_cs   <= w_cs_nxt;
      r_ym_addr <= w_addr_nxt;
      r_ym_din  <= w_din_nxt;
      r_ym_wr_n <= w_wr_n_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Per-chip busy timers; a load at strobe end wins over the cen decrement.
  always_ff @(posedge clk_jt) begin
    for (int i = 0; i < int'(YM_COUNT); i++) begin
      if (rst)                                  r_timer[i] <= '0;
      else if (w_load && r_ym_cs == 5'(i + 1))  r_timer[i] <= w_load_val;
      else if (cen && r_timer[i] != '0)         r_timer[i] <= r_timer[i] - TIMER_W'(1);
    end
  end

  assign ym_cs   = r_ym_cs;
  assign ym_addr = r_ym_addr;
  assign ym_din  = r_ym_din;
  assign ym_wr_n = r_ym_wr_n;
  assign err_cs  = r_err;
  assign busy    = !w_empty || (r_state != ST_IDLE) || !w_timers_idle;

endmodule

// File: tb/tb_spindash_write_sched.sv
// Scoreboard bench for spindash_write_sched with a cen-count timing model.
module tb_spindash_write_sched;

  localparam int YMC = 7;
  localparam int AWT = 17;
  localparam int DWT = 83;

  logic       clk_jt = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_cs = '0;
  logic [1:0] in_addr = '0;
  logic [7:0] in_din = '0;
  logic [4:0] ym_cs;
  logic [1:0] ym_addr;
  logic [7:0] ym_din;
  logic       ym_wr_n;
  logic [4:0] level;
  logic       err_cs;
  logic       busy;

  spindash_write_sched dut (
    .clk_jt(clk_jt), .rst(rst), .cen(cen), .in_valid(in_valid), .in_ready(in_ready),
    .in_cs(in_cs), .in_addr(in_addr), .in_din(in_din), .ym_cs(ym_cs), .ym_addr(ym_addr),
    .ym_din(ym_din), .ym_wr_n(ym_wr_n), .level(level), .err_cs(err_cs), .busy(busy)
  );

  always #5 clk_jt = ~clk_jt;

  typedef struct { int cs; int addr; int din; int n; } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cen_n = 0;
  int   cdiv = 0;
  int   fsm_free = 0;
  int   chip_free [32];
  int   err_seen = 0;
  logic pend_acc = 1'b0;
  exp_t exp_wr [$];
  exp_t exp_err [$];
  int   fall_log [$];

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // cen: one clk_jt in six, changed away from the active edge
  always @(posedge clk_jt) begin
    #2;
    cdiv = (cdiv == 5) ? 0 : cdiv + 1;
    cen  = (cdiv == 5);
  end

  // Reference model: when each accepted write reaches the bus, counted in cen edges
  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_accept(int cs, int addr, int din);
    exp_t e;
    int k;
    k = imax(cen_n + 1, fsm_free);
    e.cs = cs; e.addr = addr; e.din = din;
    if (cs == 0 || cs > YMC) begin
      e.n = k;
      exp_err.push_back(e);
      fsm_free = k + 1;
    end else begin
      k = imax(k, chip_free[cs]);
      e.n = k + 1;
      exp_wr.push_back(e);
      fsm_free = k + 4;
      chip_free[cs] = k + 3 + (addr[0] ? DWT : AWT);
    end
  endtask

  always @(posedge clk_jt) begin
    if (cen) cen_n++;
    if (rst) begin
      exp_wr.delete();
      exp_err.delete();
      fsm_free = 0;
      foreach (chip_free[i]) chip_free[i] = 0;
    end else if (pend_acc) begin
      model_accept(int'(in_cs), int'(in_addr), int'(in_din));
    end
  end

  // Monitor: pop expectations whenever the bus strobes or an error pulses
  logic prev_wr_n = 1'b1;
  logic in_low = 1'b0;
  int   low_clks = 0;
  exp_t cur;
  always @(posedge clk_jt) begin
    exp_t e;
    #1;
    if (rst) begin
      in_low    = 1'b0;
      prev_wr_n = 1'b1;
    end else begin
      if (err_cs) begin
        err_seen++;
        check("err_expected", int'(exp_err.size() > 0), 1);
        if (exp_err.size() > 0) begin
          e = exp_err.pop_front();
          check("err_cen", cen_n, e.n);
        end
      end
      if (in_low) begin
        low_clks++;
        if (ym_wr_n) begin
          check("strobe_width", low_clks, 6);
          check("strobe_cs_held", int'(ym_cs), cur.cs);
          in_low = 1'b0;
        end
      end
      if (prev_wr_n && !ym_wr_n) begin
        fall_log.push_back(cen_n);
        check("strobe_expected", int'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          cur = exp_wr.pop_front();
          check("strobe_cen", cen_n, cur.n);
          check("strobe_cs", int'(ym_cs), cur.cs);
          check("strobe_addr", int'(ym_addr), cur.addr);
          check("strobe_din", int'(ym_din), cur.din);
          in_low   = 1'b1;
          low_clks = 0;
        end
      end
      prev_wr_n = ym_wr_n;
    end
  end

  task automatic step();
    @(posedge clk_jt);
    #2;
  endtask

  task automatic push(int cs, int addr, int din);
    int t = 0;
    in_valid = 1'b1;
    in_cs = 5'(cs); in_addr = 2'(addr); in_din = 8'(din);
    pend_acc = in_ready;
    while (!pend_acc && t < 5000) begin
      step();
      pend_acc = in_ready;
      t++;
    end
    check("push_accept_in_time", int'(pend_acc), 1);
    step();
    in_valid = 1'b0;
    pend_acc = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int t = 0;
    while ((busy || in_low || exp_wr.size() > 0 || exp_err.size() > 0) && t < budget) begin
      step();
      t++;
    end
    check("drain_in_time", int'(t < budget), 1);
  endtask

  initial begin
    int n0;
    repeat (3) step();
    check("rst_ym_cs", int'(ym_cs), 0);
    check("rst_ym_addr", int'(ym_addr), 0);
    check("rst_ym_din", int'(ym_din), 0);
    check("rst_wr_n", int'(ym_wr_n), 1);
    check("rst_level", int'(level), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err_cs), 0);
    rst = 1'b0;
    repeat (4) step();

    // single write, minimum latency
    fall_log.delete();
    push(1, 0, 8'h28);
    wait_idle(2000);
    check("single_strobes", fall_log.size(), 1);

    // same chip, address then data: gated by the address busy time
    fall_log.delete();
    push(2, 0, 8'h30);
    push(2, 1, 8'h71);
    wait_idle(3000);
    check("samechip_strobes", fall_log.size(), 2);
    if (fall_log.size() == 2) check("samechip_gap", fall_log[1] - fall_log[0], AWT + 3);

    // three chips interleave every 4 cen; chip 1 again waits its data time
    fall_log.delete();
    push(1, 1, 8'h11);
    push(2, 1, 8'h22);
    push(3, 1, 8'h33);
    push(1, 1, 8'h44);
    wait_idle(3000);
    check("multi_strobes", fall_log.size(), 4);
    if (fall_log.size() == 4) begin
      check("multi_gap_1_2", fall_log[1] - fall_log[0], 4);
      check("multi_gap_2_3", fall_log[2] - fall_log[1], 4);
      check("multi_gap_1_1", fall_log[3] - fall_log[0], DWT + 3);
    end

    // fill the queue behind a busy chip
    fall_log.delete();
    push(4, 1, 8'hC0);
    n0 = 0;
    while ((fall_log.size() == 0 || in_low) && n0 < 500) begin step(); n0++; end
    for (int i = 0; i < 16; i++) push(4, 1, i);
    check("full_level", int'(level), 16);
    check("full_in_ready", int'(in_ready), 0);
    in_valid = 1'b1; in_cs = 5'd4; in_addr = 2'd1; in_din = 8'hEE;
    pend_acc = in_ready;
    repeat (8) begin step(); pend_acc = in_ready; end
    in_valid = 1'b0; pend_acc = 1'b0;
    check("full_level_held", int'(level), 16);
    wait_idle(12000);
    check("full_drain_strobes", fall_log.size(), 17);

    // out-of-range chip selects are dropped with an error pulse
    fall_log.delete();
    n0 = err_seen;
    push(0, 0, 8'h01);
    push(9, 1, 8'h02);
    push(3, 0, 8'h55);
    wait_idle(2000);
    check("badcs_err_pulses", err_seen - n0, 2);
    check("badcs_strobes", fall_log.size(), 1);

    // reset in the middle of a strobe
    push(5, 1, 8'hAA);
    push(5, 0, 8'hBB);
    n0 = 0;
    while (ym_wr_n && n0 < 2000) begin step(); n0++; end
    check("abort_strobe_seen", int'(ym_wr_n), 0);
    rst = 1'b1;
    step();
    check("abort_wr_n", int'(ym_wr_n), 1);
    check("abort_cs", int'(ym_cs), 0);
    check("abort_level", int'(level), 0);
    rst = 1'b0;
    fall_log.delete();
    repeat (600) step();
    check("abort_no_strobes", fall_log.size(), 0);

    // randomized traffic, including some bad chip selects
    for (int i = 0; i < 120; i++) begin
      int cs;
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 7) == 0) cs = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(8, 31);
      else cs = $urandom_range(1, YMC);
      push(cs, $urandom_range(0, 3), $urandom_range(0, 255));
    end
    wait_idle(40000);
    check("final_wr_queue_empty", exp_wr.size(), 0);
    check("final_err_queue_empty", exp_err.size(), 0);
    check("final_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
